mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Multi-cycle multiply/divide controller owning the HI/LO register pair.
//  - Accepts MD ops from the E stage.
//  - Holds the result for a fixed latency, then commits it to HI/LO.
//  - Raises busy and the pipeline stall request used by the hazard logic.
//  - Sits beside the ALU in E; MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD/MADDU if enabled); must be >= 1
//  DIV_CYCLES   10  busy cycles for DIV/DIVU; must be >= 1
// PORTS
//  clk        in   1   system clock, rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  md_start   in   1   E-stage MD op valid this cycle (not stalled/flushed)
//  md_op      in   4   op code, see mdu_defs.vh
//  rs_val     in   32  forwarded rs operand
//  rt_val     in   32  forwarded rt operand
//  d_md_use   in   1   D-stage instr is MULT/DIV/MFHI/MFLO/MTHI/MTLO (or MADD*)
//  hi         out  32  architectural HI
//  lo         out  32  architectural LO
//  busy       out  1   multi-cycle op in flight
//  md_stall   out  1   stall request to D stage
// BEHAVIOUR
//  Reset (async, reset_n=0):
//  - state=IDLE; hi, lo, pending regs and counter = 0; busy=0.
//  - Reset mid-operation discards the pending result.
//  Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU.
//  FSM states: IDLE, MUL_BUSY, DIV_BUSY.
//  - IDLE & md_start & op in {MULT,MULTU}: capture 64-bit product into {p_hi,p_lo};
//    cnt<=MULT_CYCLES; ->MUL_BUSY.
//  - IDLE & md_start & op in {DIV,DIVU}: p_lo<=quotient, p_hi<=remainder;
//    cnt<=DIV_CYCLES; ->DIV_BUSY.
//  - IDLE & md_start & MTHI/MTLO: hi/lo<=rs_val at that edge; no busy.
//  - BUSY: cnt decrements each cycle. When cnt==1: hi<=p_hi, lo<=p_lo; ->IDLE.
//  - Latency: busy is high for exactly N cycles after the start edge.
//    New hi/lo are visible in the first cycle busy=0.
//  - md_start while busy: ignored. The stall logic guarantees this never occurs;
//    the bench asserts it.
//  - Unknown or NOP op with md_start: no effect.
//  Arithmetic:
//  - Signed ops sign-extend to 64 bits; unsigned ops zero-extend.
//  - Division truncates toward zero; remainder takes the sign of the dividend.
//  - Divide by zero (rt_val==0): p_hi=rs_val, p_lo=32'hFFFF_FFFF. Normal latency applies.
//  - Signed 0x8000_0000 / -1: lo=0x8000_0000, hi=0.
//  Stall: md_stall = d_md_use & (busy | (md_start & op in MULT/MULTU/DIV/DIVU[/MADD*])).
//  - Combinational; no registered outputs besides hi/lo/busy.
// CONFIGURATION
//  Macro MDU_MADD_EN.
//  - Defined: ops 7/8 accumulate {hi,lo} += signed/unsigned product (64-bit, wraps).
//    Uses MULT_CYCLES latency. The accumulate base is {hi,lo} sampled at the start edge.
//  - Undefined: ops 7/8 are treated as NOP and excluded from md_stall.
// STRUCTURE
//  - Shared header mdu_defs.vh: MD op codes (`MD_NOP..`MD_MADDU) and FSM state encodings.
//    The D-stage decoder also includes this header.
//  - One sub-module, mdu_core: combinational 64-bit product, quotient/remainder,
//    divide-by-zero rule.
//  - mdu_ctrl holds the FSM, counter, pending and HI/LO registers.
// TESTING
//  1. MULT rs=0xFFFF_FFFE(-2), rt=3 -> busy 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
//  2. DIVU rs=100, rt=7 -> busy 10 cycles; lo=14, hi=2.
//     DIV rs=-7, rt=2 -> lo=-3, hi=-1.
//  3. DIV rt=0, rs=0x1234 -> after 10 cycles: hi=0x1234, lo=0xFFFF_FFFF.
//  4. MTLO 0xDEAD during IDLE -> lo=0xDEAD next cycle, busy never set.
//     d_md_use=1 with busy=1 -> md_stall=1 every busy cycle; 0 once busy drops.
//  5. Assert reset_n=0 in the 3rd busy cycle of MULT -> busy, hi, lo = 0 immediately;
//     no commit after release.
//  6. (MDU_MADD_EN) hi=0, lo=0xFFFF_FFFF; MADDU 1*1 -> after 5 cycles: hi=1, lo=0.
//     Without the macro: op 7 leaves hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared MD op codes, FSM state encoding and op classification for the MDU and D-stage decoder.
// Optional feature macro: MDU_MADD_EN (ops 7/8 accumulate into HI/LO when defined).
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } md_state_e;

    // Ops that occupy the unit for multiple cycles and therefore stall the D stage.
    function automatic logic is_long_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational MD datapath: 64-bit product/accumulate, truncating quotient/remainder, div-by-zero rule.
// Result is {hi, lo}; whether ops 7/8 are used at all is decided by mdu_ctrl (MDU_MADD_EN).
module mdu_core
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [63:0] acc,
    output logic [63:0] res
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic        sdiv;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign sprod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign uprod = {32'd0, rs} * {32'd0, rt};

    // Signed divide runs on magnitudes; 0x8000_0000 stays 0x8000_0000 as an unsigned magnitude.
    assign sdiv   = (op == MD_DIV);
    assign a_mag  = (sdiv && rs[31]) ? -rs : rs;
    assign b_mag  = (sdiv && rt[31]) ? -rt : rt;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (sdiv && (rs[31] ^ rt[31])) ? -q_mag : q_mag;
    assign rem    = (sdiv && rs[31]) ? -r_mag : r_mag;

    always_comb begin
        res = 64'd0;
        case (op)
            MD_MULT:         res = sprod;
            MD_MULTU:        res = uprod;
            MD_DIV, MD_DIVU: res = (rt == 32'd0) ? {rs, 32'hFFFF_FFFF} : {rem, quo};
            MD_MADD:         res = acc + sprod;
            MD_MADDU:        res = acc + uprod;
            default:         res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MD controller owning HI/LO: holds a result for MULT_CYCLES/DIV_CYCLES, then commits.
// md_stall is combinational; ops 7/8 start MADD/MADDU only when MDU_MADD_EN is defined.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state;
    logic [CW-1:0] cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic [63:0] core_res;
    logic        start_long;
    logic        start_div;

    mdu_core u_core (
        .op  (md_op),
        .rs  (rs_val),
        .rt  (rt_val),
        .acc ({hi, lo}),
        .res (core_res)
    );

    assign start_long = md_start & is_long_op(md_op);
    assign start_div  = md_start & is_div_op(md_op);
    assign md_stall   = d_md_use & (busy | start_long);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_long) begin
                        {p_hi, p_lo} <= core_res;
                        busy         <= 1'b1;
                        state        <= start_div ? DIV_BUSY : MUL_BUSY;
                        cnt          <= start_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    end else if (md_start && (md_op == MD_MTHI)) begin
                        hi <= rs_val;
                    end else if (md_start && (md_op == MD_MTLO)) begin
                        lo <= rs_val;
                    end
                end
                MUL_BUSY, DIV_BUSY: begin
                    // md_start is ignored here; the hazard logic keeps it low while busy.
                    if (cnt == CW'(1)) begin
                        hi    <= p_hi;
                        lo    <= p_lo;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Table-driven bench for mdu_ctrl with a hi/lo/latency scoreboard and a reset-mid-op sequence.
// Build with or without MDU_MADD_EN; the table adapts to the configuration.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        md_start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        d_md_use = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .md_start (md_start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_md_use (d_md_use),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          upd_hi;
        bit          upd_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input int lat, input logic [31:0] h, input logic [31:0] l,
                                input bit uh, input bit ul);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.lat = lat;
        v.hi = h; v.lo = l; v.upd_hi = uh; v.upd_lo = ul;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic use_d);
        exp_t e;
        int   n;
        e.hi  = v.upd_hi ? v.hi : m_hi;
        e.lo  = v.upd_lo ? v.lo : m_lo;
        e.lat = v.lat;
        sb.push_back(e);
        @(negedge clk);
        md_start = 1'b1; md_op = v.op; rs_val = v.rs; rt_val = v.rt; d_md_use = use_d;
        #1;
        chk("stall_at_issue", md_stall, (use_d && v.lat > 0));
        @(posedge clk);
        #1;
        md_start = 1'b0; md_op = 4'd0;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            chk("stall_busy", md_stall, use_d);
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("busy_off", busy, 0);
        chk("stall_idle", md_stall, 0);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
        d_md_use = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset_n && md_start && busy) begin
            errors++;
            $display("FAIL start_while_busy: got md_start=1 busy=1 expected no start while busy");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(4'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 1));
        vecs.push_back(mk(4'd2, 32'hFFFF_FFFE, 32'd3,        5,  32'h0000_0002, 32'hFFFF_FFFA, 1, 1));
        vecs.push_back(mk(4'd4, 32'd100,       32'd7,        10, 32'd2,         32'd14,        1, 1));
        vecs.push_back(mk(4'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1));
        vecs.push_back(mk(4'd3, 32'h0000_1234, 32'd0,        10, 32'h0000_1234, 32'hFFFF_FFFF, 1, 1));
        vecs.push_back(mk(4'd3, 32'h8000_0000, 32'hFFFF_FFFF,10, 32'd0,         32'h8000_0000, 1, 1));
        vecs.push_back(mk(4'd3, 32'd7,         32'hFFFF_FFFE,10, 32'd1,         32'hFFFF_FFFD, 1, 1));
        vecs.push_back(mk(4'd4, 32'hFFFF_FFF9, 32'd2,        10, 32'd1,         32'h7FFF_FFFC, 1, 1));
        vecs.push_back(mk(4'd6, 32'h0000_DEAD, 32'd0,        0,  32'd0,         32'h0000_DEAD, 0, 1));
        vecs.push_back(mk(4'd5, 32'h0000_BEEF, 32'd0,        0,  32'h0000_BEEF, 32'd0,         1, 0));
        vecs.push_back(mk(4'd0, 32'h1234_5678, 32'd9,        0,  32'd0,         32'd0,         0, 0));
        vecs.push_back(mk(4'd9, 32'h1234_5678, 32'd9,        0,  32'd0,         32'd0,         0, 0));
        vecs.push_back(mk(4'd4, 32'd5,         32'd0,        10, 32'd5,         32'hFFFF_FFFF, 1, 1));
        vecs.push_back(mk(4'd1, 32'h8000_0000, 32'h8000_0000,5,  32'h4000_0000, 32'd0,         1, 1));
        vecs.push_back(mk(4'd5, 32'd0,         32'd0,        0,  32'd0,         32'd0,         1, 0));
        vecs.push_back(mk(4'd6, 32'hFFFF_FFFF, 32'd0,        0,  32'd0,         32'hFFFF_FFFF, 0, 1));
`ifdef MDU_MADD_EN
        vecs.push_back(mk(4'd8, 32'd1,         32'd1,        5,  32'd1,         32'd0,         1, 1));
        vecs.push_back(mk(4'd7, 32'hFFFF_FFFF, 32'd1,        5,  32'd0,         32'hFFFF_FFFF, 1, 1));
`else
        vecs.push_back(mk(4'd8, 32'd1,         32'd1,        0,  32'd0,         32'd0,         0, 0));
        vecs.push_back(mk(4'd7, 32'hFFFF_FFFF, 32'd1,        0,  32'd0,         32'd0,         0, 0));
`endif

        #12;
        chk("reset_busy", busy, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_stall", md_stall, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], (i % 2 == 1));

        // Reset in the third busy cycle of a MULT must discard the pending result.
        run_vec(mk(4'd5, 32'h55, 32'd0, 0, 32'h55, 32'd0, 1, 0), 1'b0);
        run_vec(mk(4'd6, 32'h66, 32'd0, 0, 32'd0,  32'h66, 0, 1), 1'b0);
        @(negedge clk);
        md_start = 1'b1; md_op = 4'd1; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
        @(posedge clk);
        #1;
        md_start = 1'b0; md_op = 4'd0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_hi", hi, 0);
        chk("midreset_lo", lo, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("postreset_busy", busy, 0);
        chk("postreset_hi", hi, 0);
        chk("postreset_lo", lo, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
